// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB memory completer and its address decoder.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int PPROT_PRIV = 0;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lsb_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_addr_check.sv
// Combinational decode of an APB request into a word index and the four error terms.
module apb_addr_check
  import apb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 16,
  parameter int PRIV_ONLY = 0
) (
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       pwrite,
  input  logic [strb_w(DATA_W)-1:0]  pstrb,
  input  logic [2:0]                 pprot,
  output logic [$clog2(DEPTH)-1:0]   index,
  output logic                       err_align,
  output logic                       err_range,
  output logic                       err_prot,
  output logic                       err_strb
);

  localparam int LSB   = lsb_w(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] word_addr;
  logic              unused_prot;

  assign word_addr = paddr >> LSB;
  assign index     = paddr[LSB +: IDX_W];
  assign err_range = (word_addr >= ADDR_W'(DEPTH));
  assign err_prot  = (PRIV_ONLY != 0) && !pprot[PPROT_PRIV];
  assign err_strb  = !pwrite && (pstrb != '0);

  // Only the privileged bit of PPROT carries meaning here.
  assign unused_prot = ^pprot[2:1];

  generate
    if (LSB == 0) begin : g_no_align
      assign err_align = 1'b0;
    end else begin : g_align
      assign err_align = (paddr[LSB-1:0] != '0);
    end
  endgenerate

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 completer backed by a DEPTH x DATA_W byte-strobed store with wait states and PSLVERR.
// Handshake: a transfer completes on the rising PCLK edge where PSEL & PENABLE & PREADY are all 1;
// PRDATA and PSLVERR are meaningful only while PREADY=1, and dropping PSEL mid-access aborts silently.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0,
  parameter int PRIV_ONLY   = 0
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  input  logic [strb_w(DATA_W)-1:0]  PSTRB,
  input  logic [2:0]                 PPROT,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output apb_state_e                 dbg_state
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  apb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pready_q, pready_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;

  logic [IDX_W-1:0]   idx_q;
  logic               err_q;
  logic               write_q;
  logic [STRB_W-1:0]  strb_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [IDX_W-1:0]   dec_idx;
  logic               dec_align, dec_range, dec_prot, dec_strb, dec_err;

  logic               setup_edge;
  logic               capture;
  logic               commit;
  logic [IDX_W-1:0]   rsp_idx;
  logic               rsp_err;
  logic               rsp_wr;
  logic [DATA_W-1:0]  rsp_data;

  apb_addr_check #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .PRIV_ONLY (PRIV_ONLY)
  ) u_addr_check (
    .paddr     (PADDR),
    .pwrite    (PWRITE),
    .pstrb     (PSTRB),
    .pprot     (PPROT),
    .index     (dec_idx),
    .err_align (dec_align),
    .err_range (dec_range),
    .err_prot  (dec_prot),
    .err_strb  (dec_strb)
  );

  assign dec_err    = dec_align | dec_range | dec_prot | dec_strb;
  assign setup_edge = PSEL && !PENABLE && (state_q == IDLE);

  // With zero wait states the response is loaded on the setup edge itself, before the capture lands.
  assign rsp_idx  = (state_q == IDLE) ? dec_idx : idx_q;
  assign rsp_err  = (state_q == IDLE) ? dec_err : err_q;
  assign rsp_wr   = (state_q == IDLE) ? PWRITE  : write_q;
  assign rsp_data = (!rsp_wr && !rsp_err) ? mem_q[rsp_idx] : '0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    capture   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        pready_d = 1'b0;
        if (setup_edge) begin
          capture = 1'b1;
          state_d = ACCESS;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = rsp_err;
            prdata_d  = rsp_data;
          end else begin
            cnt_d = CNT_W'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (PENABLE) begin
          if (!pready_q) begin
            if (cnt_q > CNT_W'(1)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              cnt_d     = '0;
              pready_d  = 1'b1;
              pslverr_d = rsp_err;
              prdata_d  = rsp_data;
            end
          end else begin
            commit    = write_q && !err_q;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      if (capture) begin
        idx_q   <= dec_idx;
        err_q   <= dec_err;
        write_q <= PWRITE;
        strb_q  <= PSTRB;
      end
      // Write data is taken from the bus at the completion edge; lanes come from the setup-edge strobes.
      if (commit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[b]) begin
            mem_q[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
          end
        end
      end
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed and random checks of apb_mem_slave across zero-wait, three-wait and privileged-only builds.
module tb_apb_mem_slave;
  import apb_pkg::*;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  // index 0: WAIT_STATES=0, 1: WAIT_STATES=3, 2: PRIV_ONLY=1
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [3:0]  pstrb   [3];
  logic [2:0]  pprot   [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  apb_state_e  dbg     [3];

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0), .PRIV_ONLY(0)) u_ws0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .dbg_state(dbg[0]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(3), .PRIV_ONLY(0)) u_ws3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .dbg_state(dbg[1]));

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0), .PRIV_ONLY(1)) u_priv (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PSTRB(pstrb[2]), .PPROT(pprot[2]),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .dbg_state(dbg[2]));

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [31:0] rdata, output logic err, output int cyc);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb; pprot[d] = prot;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    cyc = 1;
    while (!pready[d] && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
    end
    check("pready_seen", {31'b0, pready[d]}, 32'd1);
    rdata = prdata[d];
    err   = pslverr[d];
    @(posedge pclk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    presetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0;
      pwdata[d] = 0; pstrb[d] = 0; pprot[d] = 0;
    end
    for (int i = 0; i < 16; i++) model[i] = '0;

    #12;
    check("rst_pready",  {31'b0, pready[0]}, 32'd0);
    check("rst_pslverr", {31'b0, pslverr[0]}, 32'd0);
    check("rst_prdata",  prdata[0], 32'd0);
    check("rst_state",   {31'b0, dbg[0]}, {31'b0, IDLE});
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    // ---------------- directed table on the zero-wait build ----------------
    tbl[0]  = '{1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h04, 32'h11223344, 4'h5, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00220044, 1'b0};
    tbl[4]  = '{1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1};
    tbl[5]  = '{1'b1, 32'h06, 32'h55555555, 4'hF, 32'h0,        1'b1};
    tbl[6]  = '{1'b0, 32'h08, 32'h0,        4'h1, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00220044, 1'b0};
    tbl[9]  = '{1'b1, 32'h3C, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'hAABBCCDD, 1'b0};
    tbl[11] = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[12] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'h00220044, 1'b0};
    tbl[13] = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[14] = '{1'b1, 32'h08, 32'h00007700, 4'h2, 32'h0,        1'b0};
    tbl[15] = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hDEAD77EF, 1'b0};

    for (int i = 0; i < 16; i++) begin
      xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, 3'b000, rd, er, cyc);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      check($sformatf("tbl%0d_cycles", i), cyc, 32'd1);
    end

    // ---------------- privileged-only build ----------------
    xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, 3'b000, rd, er, cyc);
    check("priv_wr_user_err", {31'b0, er}, 32'd1);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("priv_rd_after_reject", rd, 32'h0);
    check("priv_rd_after_reject_err", {31'b0, er}, 32'd0);
    xfer(2, 1'b1, 32'h08, 32'h12345678, 4'hF, 3'b001, rd, er, cyc);
    check("priv_wr_ok_err", {31'b0, er}, 32'd0);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check("priv_rd_user_data", rd, 32'h0);
    check("priv_rd_user_err", {31'b0, er}, 32'd1);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, rd, er, cyc);
    check("priv_rd_data", rd, 32'h12345678);

    // ---------------- three wait states ----------------
    xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, cyc);
    check("ws3_wr_cycles", cyc, 32'd4);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check("ws3_rd_cycles", cyc, 32'd4);
    check("ws3_rd_data", rd, 32'hDEADBEEF);
    check("ws3_rd_err", {31'b0, er}, 32'd0);

    // abort mid-wait: PSEL dropped after one access cycle
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h0C; pwdata[1] = 32'h87654321; pstrb[1] = 4'hF;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    check("abort_pready_low", {31'b0, pready[1]}, 32'd0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    check("abort_state_idle", {31'b0, dbg[1]}, {31'b0, IDLE});
    check("abort_pready_idle", {31'b0, pready[1]}, 32'd0);
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, er, cyc);
    check("abort_word_zero", rd, 32'h0);
    check("abort_next_err", {31'b0, er}, 32'd0);
    check("abort_next_cycles", cyc, 32'd4);

    // ---------------- reset in the middle of an access ----------------
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0;
    paddr[0] = 32'h08; pstrb[0] = 4'h0;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    check("mid_rst_pready_before", {31'b0, pready[0]}, 32'd1);
    #2 presetn = 1'b0;
    #1;
    check("mid_rst_pready_after", {31'b0, pready[0]}, 32'd0);
    check("mid_rst_prdata", prdata[0], 32'd0);
    check("mid_rst_state", {31'b0, dbg[0]}, {31'b0, IDLE});
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    for (int i = 0; i < 16; i++) begin
      xfer(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 3'b000, rd, er, cyc);
      check($sformatf("post_rst_word%0d", i), rd, 32'h0);
    end

    // ---------------- random back-to-back against a reference model ----------------
    for (int n = 0; n < 200; n++) begin
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        exp_err;
      logic [31:0] exp_rd;
      int          widx;
      wr    = 1'($urandom_range(0, 1));
      addr  = 32'($urandom_range(0, 17)) << 2;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      if (!wr && $urandom_range(0, 7) != 0) strb = 4'h0;
      widx    = int'(addr >> 2);
      exp_err = (addr[1:0] != 2'b00) || (widx >= 16) || (!wr && strb != 4'h0);
      exp_rd  = (!wr && !exp_err) ? model[widx] : 32'h0;
      exp_q.push_back(exp_rd);
      if (wr && !exp_err) begin
        for (int b = 0; b < 4; b++) begin
          if (strb[b]) model[widx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      xfer(0, wr, addr, wdata, strb, 3'($urandom_range(0, 7)), rd, er, cyc);
      check($sformatf("rnd%0d_rdata", n), rd, exp_q.pop_front());
      check($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, exp_err});
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
